vending_machine_client: RTL
===========================

Name: vending_machine_client

Overview:
- Customer-side agent for the vending-machine client, serve and change interfaces.
- Accepts a purse (coin counts) on a request port and inserts coins one per cycle, largest denomination first.
- Requests dispense, then acts as the serve responder and the change responder.
- Reports the change received and an error flag on a response port.
- Used as a bench driver and as the plant-side model for top-level integration of the vending machine.

Parameters:
- PRICE, 8, drink price in nickel units.
- SERVE_LAT, 2, cycles from observed serve_emit_irn_bru_r to the serve_done pulse (>=1).
- CHANGE_LAT, 1, cycles from observed change_emit_dime_r to the change_done pulse (>=1).
- CW, 8, width of credit and change counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- req_vld  in  1  purse request valid
- req_rdy  out  1  high in IDLE only
- req_nickels  in  4  nickels available
- req_dimes  in  4  dimes available
- req_quarters  in  4  quarters available
- client_nickel  out  1  insert-nickel pulse
- client_dime  out  1  insert-dime pulse
- client_quarter  out  1  insert-quarter pulse
- client_dispense  out  1  dispense request, held as a level
- client_enough_r  in  1  machine credit >= price
- serve_emit_irn_bru_r  in  1  machine serving a drink (1-cycle pulse)
- serve_done  out  1  serve complete pulse
- change_emit_dime_r  in  1  one nickel unit of change emitted (1-cycle pulse)
- change_done  out  1  change accepted pulse
- rsp_vld  out  1  transaction complete, 1-cycle pulse
- rsp_change  out  CW  nickel units of change received
- rsp_err  out  1  insufficient purse or change mismatch

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE. All outputs 0 except req_rdy=1. Purse, credit, change and latency counters cleared. Reset mid-transaction abandons it with no rsp_vld.
- At most one coin output is high per cycle. Coin outputs and client_dispense are registered.
- Coin values: nickel=1, dime=2, quarter=5. credit is CW bits wide, cannot overflow (max 15*8=120).
- IDLE: on req_vld&&req_rdy, latch the purse and compute total = N + 2D + 5Q.
  - If total < PRICE: go to RESP with rsp_err=1, rsp_change=0; no coins inserted.
  - Otherwise go to INSERT.
- INSERT: each cycle insert one coin, choosing quarter if any remain, else dime, else nickel. Decrement that purse count and add its value to credit. When the post-insert credit >= PRICE, go to WAIT_ENOUGH. expected_change = credit - PRICE.
- WAIT_ENOUGH: wait for client_enough_r==1, then go to DISPENSE. The machine's flag rises one cycle after the crossing coin.
- DISPENSE: hold client_dispense=1 until serve_emit_irn_bru_r is sampled high; deassert the following cycle. Start the serve latency counter and go to SERVE.
- SERVE: after SERVE_LAT cycles, pulse serve_done for one cycle.
  - If expected_change==0, go to RESP.
  - Otherwise go to CHANGE.
- CHANGE: each sampled change_emit_dime_r increments rcvd and arms a CHANGE_LAT counter. On expiry, pulse change_done once.
  - When rcvd==expected_change and the last change_done has been pulsed, go to RESP.
  - An emit while the latency counter is armed sets err and is still counted.
- RESP: one cycle with rsp_vld=1, rsp_change=rcvd, rsp_err=err; then IDLE.
- Emits arriving outside CHANGE are ignored and do not set err. Excess emits after RESP belong to no transaction.
- serve_emit_irn_bru_r seen in any state other than DISPENSE/SERVE is ignored.

Optional Feature:
- Macro VM_CLIENT_WATCHDOG_EN.
- Defined: a 10-bit counter clears on every state change and increments otherwise in WAIT_ENOUGH, DISPENSE, SERVE and CHANGE. At 1023 it forces RESP with rsp_err=1 and rsp_change=rcvd, and drops client_dispense.
- Not defined: no counter; the block waits indefinitely in those states.

Test Plan:
- Purse Q=1,D=1,N=1, PRICE=8 -> coin sequence quarter, dime, nickel on consecutive cycles. Dispense held until serve_emit. serve_done exactly 2 cycles after serve_emit. rsp_vld with change=0, err=0.
- Purse Q=2 -> two quarters, credit 10, expected change 2. Two change_emit pulses, each answered by change_done 1 cycle later. rsp_change=2, err=0.
- Purse N=3,D=1 (total 5) -> no coin pulses. rsp_vld on the cycle after acceptance with err=1, change=0.
- Purse Q=2, machine model emits 3 change pulses -> rsp after the 2nd change_done with change=2, err=0. The 3rd emit is ignored.
- Assert rst=0 while in DISPENSE -> next cycle client_dispense=0, req_rdy=1, no rsp_vld. A new request completes normally.
- With VM_CLIENT_WATCHDOG_EN defined, client_enough_r held 0 -> after 1023 cycles in WAIT_ENOUGH, rsp_vld=1 with err=1.

Source files
------------

// File: rtl/vending_machine_client.sv
// Customer-side agent: inserts coins, requests dispense, answers serve/change.
// Optional watchdog enabled by defining VM_CLIENT_WATCHDOG_EN.
module vending_machine_client #(
  parameter int PRICE      = 8,
  parameter int SERVE_LAT  = 2,
  parameter int CHANGE_LAT = 1,
  parameter int CW         = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_vld,
  output logic          req_rdy,
  input  logic [3:0]    req_nickels,
  input  logic [3:0]    req_dimes,
  input  logic [3:0]    req_quarters,
  output logic          client_nickel,
  output logic          client_dime,
  output logic          client_quarter,
  output logic          client_dispense,
  input  logic          client_enough_r,
  input  logic          serve_emit_irn_bru_r,
  output logic          serve_done,
  input  logic          change_emit_dime_r,
  output logic          change_done,
  output logic          rsp_vld,
  output logic [CW-1:0] rsp_change,
  output logic          rsp_err
);

  localparam int LW = 8;

  typedef enum logic [2:0] {
    IDLE, INSERT, WAIT_ENOUGH, DISPENSE, SERVE, CHANGE, RESP
  } state_t;

  state_t        state, state_n;
  logic [3:0]    n_q, d_q, q_q;
  logic [CW-1:0] credit, exp_chg, rcvd;
  logic          err;
  logic [LW-1:0] scnt, ccnt;
  logic          armed;
  logic          coin_n, coin_d, coin_q, disp;

  logic [CW-1:0] total, coin_val, credit_nx;
  logic          pick_q, pick_d;
  logic          serve_fire, change_fire, emit, last;
  logic          wd_hit;

  assign total = CW'(req_nickels) + (CW'(req_dimes) << 1)
               + CW'(req_quarters) * CW'(5);

  assign pick_q    = (q_q != 4'd0);
  assign pick_d    = !pick_q && (d_q != 4'd0);
  assign coin_val  = pick_q ? CW'(5) : (pick_d ? CW'(2) : CW'(1));
  assign credit_nx = credit + coin_val;

  assign serve_fire  = (state == SERVE) && (scnt == '0);
  assign change_fire = (state == CHANGE) && armed && (ccnt == '0);
  assign emit        = (state == CHANGE) && change_emit_dime_r;
  // an emit landing on the done cycle keeps the exchange open
  assign last        = change_fire && !emit && (rcvd >= exp_chg);

`ifdef VM_CLIENT_WATCHDOG_EN
  logic [9:0] wd;
  logic       wd_zone;

  assign wd_zone = (state == WAIT_ENOUGH) || (state == DISPENSE)
                || (state == SERVE) || (state == CHANGE);
  assign wd_hit  = wd_zone && (wd == 10'h3FF);

  always_ff @(posedge clk) begin
    if (!rst) wd <= '0;
    else if (state_n != state) wd <= '0;
    else if (wd_zone) wd <= wd + 10'd1;
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (req_vld)
        state_n = (total < CW'(PRICE)) ? RESP : INSERT;
      INSERT: if (credit_nx >= CW'(PRICE)) state_n = WAIT_ENOUGH;
      WAIT_ENOUGH: if (client_enough_r) state_n = DISPENSE;
      DISPENSE: if (serve_emit_irn_bru_r) state_n = SERVE;
      SERVE: if (serve_fire)
        state_n = (exp_chg == '0) ? RESP : CHANGE;
      CHANGE: if (last) state_n = RESP;
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (wd_hit) state_n = RESP;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      n_q     <= '0;
      d_q     <= '0;
      q_q     <= '0;
      credit  <= '0;
      exp_chg <= '0;
      rcvd    <= '0;
      err     <= 1'b0;
      scnt    <= '0;
      ccnt    <= '0;
      armed   <= 1'b0;
      coin_n  <= 1'b0;
      coin_d  <= 1'b0;
      coin_q  <= 1'b0;
      disp    <= 1'b0;
    end else begin
      state  <= state_n;
      coin_n <= 1'b0;
      coin_d <= 1'b0;
      coin_q <= 1'b0;
      disp   <= (state_n == DISPENSE);
      case (state)
        IDLE: if (req_vld) begin
          n_q     <= req_nickels;
          d_q     <= req_dimes;
          q_q     <= req_quarters;
          credit  <= '0;
          exp_chg <= '0;
          rcvd    <= '0;
          armed   <= 1'b0;
          err     <= (total < CW'(PRICE));
        end
        INSERT: begin
          credit <= credit_nx;
          if (pick_q) begin
            coin_q <= 1'b1;
            q_q    <= q_q - 4'd1;
          end else if (pick_d) begin
            coin_d <= 1'b1;
            d_q    <= d_q - 4'd1;
          end else begin
            coin_n <= 1'b1;
            if (n_q != 4'd0) n_q <= n_q - 4'd1;
          end
          if (credit_nx >= CW'(PRICE))
            exp_chg <= credit_nx - CW'(PRICE);
        end
        DISPENSE: if (serve_emit_irn_bru_r)
          scnt <= LW'(SERVE_LAT - 1);
        SERVE: if (scnt != '0) scnt <= scnt - 1'b1;
        CHANGE: begin
          if (emit) begin
            rcvd  <= rcvd + 1'b1;
            armed <= 1'b1;
            ccnt  <= LW'(CHANGE_LAT - 1);
            if (armed) err <= 1'b1;
          end else if (change_fire) begin
            armed <= 1'b0;
          end else if (armed) begin
            ccnt <= ccnt - 1'b1;
          end
        end
        default: ;
      endcase
      if (wd_hit) err <= 1'b1;
    end
  end

  assign req_rdy         = (state == IDLE);
  assign client_nickel   = coin_n;
  assign client_dime     = coin_d;
  assign client_quarter  = coin_q;
  assign client_dispense = disp;
  assign serve_done      = serve_fire;
  assign change_done     = change_fire;
  assign rsp_vld         = (state == RESP);
  assign rsp_change      = (state == RESP) ? rcvd : '0;
  assign rsp_err         = (state == RESP) && err;

endmodule
